// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around the shared 16-bit ALU: builds 16x16 multiply (low half,
// shift-and-add) and 0..15-place shifts from single-pass ALU operations.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] alu_rsdata,
    output logic [WIDTH-1:0] alu_rmdata,
    output logic [WIDTH-1:0] alu_n,
    output logic             alu_instr_bit_15,
    output logic [1:0]       alu_instr_bit_12_11,
    output logic             alu_instr_bit_4,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {StIdle, StMAdd, StMShl, StMShr, StSh} state_e;

    localparam logic [1:0] CmdMul = 2'b00;
    localparam logic [1:0] CmdLsl = 2'b01;
    localparam logic [1:0] CmdLsr = 2'b10;
    localparam logic [1:0] CmdAsr = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            val_q    <= '0;
            rem_q    <= '0;
            cmd_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            val_q    <= val_d;
            rem_q    <= rem_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        val_d    = val_q;
        rem_d    = rem_q;
        cmd_d    = cmd_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cmd_d = cmd;
                    if (cmd == CmdMul) begin
                        acc_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        state_d  = StMAdd;
                    end else if (op_b[CNT_W-1:0] == '0) begin
                        // Zero-place shift completes without touching the ALU.
                        result_d = op_a;
                        done_d   = 1'b1;
                    end else begin
                        val_d   = op_a;
                        rem_d   = op_b[CNT_W-1:0];
                        state_d = StSh;
                    end
                end
            end
            StMAdd: begin
                acc_d   = aluout;
                state_d = StMShl;
            end
            StMShl: begin
                mcand_d = aluout;
                state_d = StMShr;
            end
            StMShr: begin
                mplier_d = aluout;
                // No multiplier bits left: the product in acc is final.
                if (aluout == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d = StMAdd;
                end
            end
            StSh: begin
                val_d = aluout;
                rem_d = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    result_d = aluout;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ALU opcode {bit15, bit12_11, bit4}: ADD-R 0000, LSL 1000, LSR 1100, ASR 1101.
    always_comb begin
        alu_rsdata          = '0;
        alu_rmdata          = '0;
        alu_instr_bit_15    = 1'b0;
        alu_instr_bit_12_11 = 2'b00;
        alu_instr_bit_4     = 1'b0;
        unique case (state_q)
            StIdle: ;
            StMAdd: begin
                alu_rsdata = acc_q;
                alu_rmdata = mplier_q[0] ? mcand_q : '0;
            end
            StMShl: begin
                alu_instr_bit_15 = 1'b1;
                alu_rsdata       = mcand_q;
            end
            StMShr: begin
                alu_instr_bit_15    = 1'b1;
                alu_instr_bit_12_11 = 2'b10;
                alu_rsdata          = mplier_q;
            end
            StSh: begin
                alu_rsdata       = val_q;
                alu_instr_bit_15 = 1'b1;
                unique case (cmd_q)
                    CmdLsr: alu_instr_bit_12_11 = 2'b10;
                    CmdAsr: begin
                        alu_instr_bit_12_11 = 2'b10;
                        alu_instr_bit_4     = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_n  = '0;
    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU model plus table-driven operations and
// hand-written reset, busy-start and back-to-back sequences.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cmd;
    logic [15:0] op_a, op_b, aluout;
    logic [15:0] alu_rsdata, alu_rmdata, alu_n;
    logic        alu_instr_bit_15, alu_instr_bit_4;
    logic [1:0]  alu_instr_bit_12_11;
    logic [15:0] result;
    logic        busy, done;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .cmd                 (cmd),
        .op_a                (op_a),
        .op_b                (op_b),
        .aluout              (aluout),
        .alu_rsdata          (alu_rsdata),
        .alu_rmdata          (alu_rmdata),
        .alu_n               (alu_n),
        .alu_instr_bit_15    (alu_instr_bit_15),
        .alu_instr_bit_12_11 (alu_instr_bit_12_11),
        .alu_instr_bit_4     (alu_instr_bit_4),
        .result              (result),
        .busy                (busy),
        .done                (done)
    );

    // The shared ALU, modelled from its opcode table.
    always_comb begin
        case ({alu_instr_bit_15, alu_instr_bit_12_11, alu_instr_bit_4})
            4'b0000: aluout = alu_rsdata + alu_rmdata;
            4'b1000: aluout = alu_rsdata << 1;
            4'b1100: aluout = alu_rsdata >> 1;
            4'b1101: aluout = {alu_rsdata[15], alu_rsdata[15:1]};
            default: aluout = 16'hDEAD;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_drive(input string name);
        check({name, "_rs"}, 32'(alu_rsdata), 32'h0);
        check({name, "_rm"}, 32'(alu_rmdata), 32'h0);
        check({name, "_op"}, 32'({alu_instr_bit_15, alu_instr_bit_12_11, alu_instr_bit_4}), 32'h0);
        check({name, "_n"}, 32'(alu_n), 32'h0);
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    // inj >= 0 pulses start (with junk operands) inj cycles into the operation.
    task automatic run_op(input string name, input logic [1:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input int exp_lat, input int inj);
        int n;
        int bcnt;
        logic held;
        logic [15:0] prev;
        prev  = result;
        cmd   = c;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        cmd   = 2'($urandom);
        n     = 0;
        bcnt  = 0;
        held  = 1'b1;
        while (!done && n < 200) begin
            if (busy) bcnt++;
            if (result !== prev) held = 1'b0;
            start = (n == inj);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_result"}, 32'(result), 32'(exp_res));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
        check({name, "_result_held"}, 32'(held), 32'h1);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  c;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[11];
    int   dcnt;

    initial begin
        // Latency counts edges after the start-sampling edge; zero-place shifts
        // show done right after the start edge itself.
        vecs[0]  = '{"mul_7x6",      2'b00, 16'h0007, 16'h0006, 16'h002A, 9};
        vecs[1]  = '{"mul_ffff",     2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 48};
        vecs[2]  = '{"mul_by0",      2'b00, 16'h1234, 16'h0000, 16'h0000, 3};
        vecs[3]  = '{"asr_4",        2'b11, 16'h8000, 16'h0004, 16'hF800, 4};
        vecs[4]  = '{"lsr_4",        2'b10, 16'h8000, 16'h0004, 16'h0800, 4};
        vecs[5]  = '{"lsl_15",       2'b01, 16'h0001, 16'h000F, 16'h8000, 15};
        vecs[6]  = '{"lsl_0",        2'b01, 16'hBEEF, 16'hFFF0, 16'hBEEF, 0};
        vecs[7]  = '{"mul_100x3",    2'b00, 16'h0100, 16'h0003, 16'h0300, 6};
        vecs[8]  = '{"asr_2_pos",    2'b11, 16'h7FF0, 16'hABC2, 16'h1FFC, 2};
        vecs[9]  = '{"mul_ff_x101",  2'b00, 16'h00FF, 16'h0101, 16'hFFFF, 27};
        vecs[10] = '{"lsr_0",        2'b10, 16'h1357, 16'h0010, 16'h1357, 0};

        reset = 1'b1;
        start = 1'b0;
        cmd   = 2'b00;
        op_a  = 16'h0;
        op_b  = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_result", 32'(result), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check_idle_drive("reset_drive");

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, -1);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 32'(done), 32'h0);
        end

        // Start pulsed mid-multiply must not disturb it.
        run_op("busy_start", 2'b00, 16'h0007, 16'h0006, 16'h002A, 9, 2);
        @(negedge clk);
        check("busy_start_no_extra", 32'({busy, done}), 32'h0);

        // Back-to-back: second start lands in the done cycle of the first.
        run_op("b2b_first", 2'b00, 16'h0005, 16'h0003, 16'h000F, 6, -1);
        run_op("b2b_second", 2'b01, 16'h0003, 16'h0002, 16'h000C, 2, -1);
        @(negedge clk);

        // Reset held two cycles in the middle of a multiply.
        cmd   = 2'b00;
        op_a  = 16'h0007;
        op_b  = 16'h0006;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        dcnt  = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        reset = 1'b0;
        check("midreset_result", 32'(result), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_done", 32'(done), 32'h0);
        check_idle_drive("midreset_drive");
        repeat (60) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midreset_no_done", 32'(dcnt), 32'h0);
        check("midreset_result_hold", 32'(result), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
